// File: rtl/neo_sndlatch.sv
// neo_sndlatch: bidirectional 68K <-> Z80 sound-command latch.
// Holds the 68K command byte for the Z80 and the Z80 reply byte for the 68K.
// Raises a timed NMI request on every new command while NMI generation is enabled.
// All strobes are sampled on CLK_24M, and their edges are detected from two
// consecutive samples.
module neo_sndlatch #(
  parameter int NMI_LEN = 24
) (
  input  logic       CLK_24M,
  input  logic       RESET,
  input  logic       nSNDWR,
  input  logic       nSNDRD,
  input  logic [7:0] M68K_DATA_IN,
  output logic [7:0] M68K_DATA_OUT,
  input  logic       nSDZ80R,
  input  logic       nSDZ80W,
  input  logic       nSDZ80CLR,
  input  logic [7:0] SDD_IN,
  output logic [7:0] SDD_OUT,
  output logic       SDD_OE,
  input  logic       NMI_EN,
  output logic       nNMI_REQ,
  output logic       CMD_PENDING,
  output logic       REPLY_READY,
  output logic [3:0] OVERRUN_CNT
);

  localparam logic [7:0] NMI_LOAD = 8'(NMI_LEN);

  // Strobe bit positions inside the packed strobe vectors
  localparam int S_WR  = 4;
  localparam int S_RD  = 3;
  localparam int S_ZR  = 2;
  localparam int S_ZW  = 1;
  localparam int S_ZC  = 0;

  logic [4:0] stb_in;
  logic [4:0] stb_cur_reg;
  logic [4:0] stb_prev_reg;
  logic       post_rst_reg;

  logic       wr_fall;
  logic       rd_rise;
  logic       zw_fall;
  logic       zc_fall;

  logic [7:0] snd_cmd_reg;
  logic [7:0] snd_reply_reg;
  logic       cmd_pending_reg;
  logic       reply_ready_reg;
  logic [3:0] overrun_cnt_reg;
  logic [7:0] m68k_dout_reg;
  logic [7:0] sdd_out_reg;
  logic       sdd_oe_reg;
  logic [7:0] nmi_cnt_reg;
  logic       nmi_req_n_reg;

  assign stb_in = {nSNDWR, nSNDRD, nSDZ80R, nSDZ80W, nSDZ80CLR};

  // Edge detection: assertion is a 1 -> 0 transition, deassertion is 0 -> 1
  assign wr_fall = stb_prev_reg[S_WR] & ~stb_cur_reg[S_WR];
  assign rd_rise = ~stb_prev_reg[S_RD] & stb_cur_reg[S_RD];
  assign zw_fall = stb_prev_reg[S_ZW] & ~stb_cur_reg[S_ZW];
  assign zc_fall = stb_prev_reg[S_ZC] & ~stb_cur_reg[S_ZC];

  // Strobe sampling; on the first cycle after reset both stages load the live
  // strobe, so a strobe that is held low through reset produces no edge
  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      stb_cur_reg  <= '1;
      stb_prev_reg <= '1;
      post_rst_reg <= 1'b1;
    end else begin
      stb_cur_reg  <= stb_in;
      stb_prev_reg <= post_rst_reg ? stb_in : stb_cur_reg;
      post_rst_reg <= 1'b0;
    end
  end

  // Command latch: a 68K write wins over a simultaneous Z80 clear
  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      snd_cmd_reg     <= 8'h00;
      cmd_pending_reg <= 1'b0;
      overrun_cnt_reg <= 4'h0;
    end else if (wr_fall) begin
      snd_cmd_reg     <= M68K_DATA_IN;
      cmd_pending_reg <= 1'b1;
      if (cmd_pending_reg && (overrun_cnt_reg != 4'hF)) begin
        overrun_cnt_reg <= overrun_cnt_reg + 4'd1;
      end
    end else if (zc_fall) begin
      snd_cmd_reg     <= 8'h00;
      cmd_pending_reg <= 1'b0;
    end
  end

  // Reply latch: a new Z80 reply wins over a simultaneous 68K read completion
  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      snd_reply_reg   <= 8'h00;
      reply_ready_reg <= 1'b0;
      m68k_dout_reg   <= 8'h00;
    end else begin
      m68k_dout_reg <= snd_reply_reg;
      if (zw_fall) begin
        snd_reply_reg   <= SDD_IN;
        reply_ready_reg <= 1'b1;
      end else if (rd_rise) begin
        reply_ready_reg <= 1'b0;
      end
    end
  end

  // Z80 read port: drive the command byte while the sampled read strobe is low
  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      sdd_oe_reg  <= 1'b0;
      sdd_out_reg <= 8'h00;
    end else begin
      sdd_oe_reg  <= ~stb_cur_reg[S_ZR];
      sdd_out_reg <= stb_cur_reg[S_ZR] ? 8'h00 : snd_cmd_reg;
    end
  end

  // NMI pulse timer; disabling NMI cancels the pulse, a new command reloads it
  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      nmi_cnt_reg   <= 8'h00;
      nmi_req_n_reg <= 1'b1;
    end else begin
      nmi_req_n_reg <= (nmi_cnt_reg == 8'h00);
      if (!NMI_EN) begin
        nmi_cnt_reg <= 8'h00;
      end else if (wr_fall) begin
        nmi_cnt_reg <= NMI_LOAD;
      end else if (nmi_cnt_reg != 8'h00) begin
        nmi_cnt_reg <= nmi_cnt_reg - 8'd1;
      end
    end
  end

  assign M68K_DATA_OUT = m68k_dout_reg;
  assign SDD_OUT       = sdd_out_reg;
  assign SDD_OE        = sdd_oe_reg;
  assign nNMI_REQ      = nmi_req_n_reg;
  assign CMD_PENDING   = cmd_pending_reg;
  assign REPLY_READY   = reply_ready_reg;
  assign OVERRUN_CNT   = overrun_cnt_reg;

endmodule

// File: tb/tb_neo_sndlatch.sv
// Testbench for neo_sndlatch: directed scenarios followed by random strobe
// traffic, all checked every cycle against an edge-indexed reference model.
module tb_neo_sndlatch;

  localparam int NMI_LEN = 24;

  logic       CLK_24M = 1'b0;
  logic       RESET = 1'b1;
  logic       nSNDWR = 1'b1;
  logic       nSNDRD = 1'b1;
  logic [7:0] M68K_DATA_IN = 8'h00;
  logic [7:0] M68K_DATA_OUT;
  logic       nSDZ80R = 1'b1;
  logic       nSDZ80W = 1'b1;
  logic       nSDZ80CLR = 1'b1;
  logic [7:0] SDD_IN = 8'h00;
  logic [7:0] SDD_OUT;
  logic       SDD_OE;
  logic       NMI_EN = 1'b0;
  logic       nNMI_REQ;
  logic       CMD_PENDING;
  logic       REPLY_READY;
  logic [3:0] OVERRUN_CNT;

  neo_sndlatch #(.NMI_LEN(NMI_LEN)) dut (
    .CLK_24M      (CLK_24M),
    .RESET        (RESET),
    .nSNDWR       (nSNDWR),
    .nSNDRD       (nSNDRD),
    .M68K_DATA_IN (M68K_DATA_IN),
    .M68K_DATA_OUT(M68K_DATA_OUT),
    .nSDZ80R      (nSDZ80R),
    .nSDZ80W      (nSDZ80W),
    .nSDZ80CLR    (nSDZ80CLR),
    .SDD_IN       (SDD_IN),
    .SDD_OUT      (SDD_OUT),
    .SDD_OE       (SDD_OE),
    .NMI_EN       (NMI_EN),
    .nNMI_REQ     (nNMI_REQ),
    .CMD_PENDING  (CMD_PENDING),
    .REPLY_READY  (REPLY_READY),
    .OVERRUN_CNT  (OVERRUN_CNT)
  );

  always #5 CLK_24M = ~CLK_24M;

  int checks_cnt = 0;
  int errors_cnt = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: strobe samples indexed by clock edge. An event at edge k
  // comes from the samples taken at edges k-2 and k-1, both outside reset.
  int       cyc = 0;
  bit [4:0] samp1 = 5'h1f, samp2 = 5'h1f;
  bit       val1 = 1'b0, val2 = 1'b0;
  int       m_cmd = 0, m_reply = 0, m_dout = 0, m_sout = 0, m_ovr = 0;
  bit       m_pend = 0, m_ready = 0, m_oe = 0, m_nmi = 1;
  int       nmi_last = -100;   // last edge at which nNMI_REQ is expected low

  function automatic void model_edge();
    bit [4:0] cur;
    bit both, wr, rdd, zw, clr;
    cur = {nSNDWR, nSNDRD, nSDZ80R, nSDZ80W, nSDZ80CLR};
    cyc++;
    if (RESET) begin
      m_cmd = 0; m_reply = 0; m_dout = 0; m_sout = 0; m_ovr = 0;
      m_pend = 0; m_ready = 0; m_oe = 0; m_nmi = 1;
      nmi_last = -100;
      samp2 = 5'h1f; samp1 = cur; val2 = 0; val1 = 0;
    end else begin
      both = val1 && val2;
      wr  = both &&  samp2[4] && !samp1[4];
      rdd = both && !samp2[3] &&  samp1[3];
      zw  = both &&  samp2[1] && !samp1[1];
      clr = both &&  samp2[0] && !samp1[0];
      // outputs that reflect state as it stood before this edge
      m_oe   = val1 && !samp1[2];
      m_sout = m_oe ? m_cmd : 0;
      m_dout = m_reply;
      m_nmi  = !(cyc <= nmi_last);
      // NMI window
      if (!NMI_EN) begin
        if (nmi_last > cyc) nmi_last = cyc;
      end else if (wr) begin
        nmi_last = cyc + NMI_LEN;
      end
      // command side
      if (wr) begin
        if (m_pend && m_ovr < 15) m_ovr++;
        m_cmd = M68K_DATA_IN;
        m_pend = 1;
      end else if (clr) begin
        m_cmd = 0;
        m_pend = 0;
      end
      // reply side
      if (zw) begin
        m_reply = SDD_IN;
        m_ready = 1;
      end else if (rdd) begin
        m_ready = 0;
      end
      samp2 = samp1; val2 = val1;
      samp1 = cur;   val1 = 1;
    end
  endfunction

  int low_cnt = 0;

  // One clock: model updates at the edge, outputs compared half a cycle later
  task automatic tick();
    @(posedge CLK_24M);
    model_edge();
    @(negedge CLK_24M);
    check("cmd_pending", int'(CMD_PENDING), int'(m_pend));
    check("reply_ready", int'(REPLY_READY), int'(m_ready));
    check("overrun_cnt", int'(OVERRUN_CNT), m_ovr);
    check("m68k_dout",   int'(M68K_DATA_OUT), m_dout);
    check("sdd_oe",      int'(SDD_OE), int'(m_oe));
    check("sdd_out",     int'(SDD_OUT), m_sout);
    check("nnmi_req",    int'(nNMI_REQ), int'(m_nmi));
    if (!nNMI_REQ) low_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_wr(input logic [7:0] d);
    M68K_DATA_IN = d; nSNDWR = 1'b0; tick(); nSNDWR = 1'b1;
  endtask

  initial begin
    // reset
    RESET = 1'b1; run(3);
    check("rst_nmi", int'(nNMI_REQ), 1);
    check("rst_pending", int'(CMD_PENDING), 0);
    RESET = 1'b0; run(2);

    // command write with NMI, then Z80 read
    NMI_EN = 1'b1;
    low_cnt = 0;
    pulse_wr(8'h5A);
    run(40);
    check("nmi_len_24", low_cnt, 24);
    check("pending_5a", int'(CMD_PENDING), 1);
    nSDZ80R = 1'b0; run(2);
    check("sdd_oe_rd", int'(SDD_OE), 1);
    check("sdd_out_5a", int'(SDD_OUT), 8'h5A);
    nSDZ80R = 1'b1; run(2);
    check("sdd_oe_idle", int'(SDD_OE), 0);

    // reply path
    SDD_IN = 8'hC3; nSDZ80W = 1'b0; tick(); nSDZ80W = 1'b1; run(3);
    check("reply_ready_c3", int'(REPLY_READY), 1);
    check("dout_c3", int'(M68K_DATA_OUT), 8'hC3);
    nSNDRD = 1'b0; run(3);
    check("ready_during_rd", int'(REPLY_READY), 1);
    nSNDRD = 1'b1; run(2);
    check("ready_after_rd", int'(REPLY_READY), 0);
    check("dout_hold_c3", int'(M68K_DATA_OUT), 8'hC3);

    // 17 writes without clear: overrun saturates
    for (int i = 1; i <= 17; i++) begin
      pulse_wr(8'(i + 8'h20)); tick();
    end
    run(2);
    check("ovr_sat", int'(OVERRUN_CNT), 15);
    nSDZ80R = 1'b0; run(2);
    check("last_cmd", int'(SDD_OUT), 8'h31);
    nSDZ80R = 1'b1; run(1);
    nSDZ80CLR = 1'b0; tick(); nSDZ80CLR = 1'b1; run(2);
    check("clr_pending", int'(CMD_PENDING), 0);
    check("clr_ovr_kept", int'(OVERRUN_CNT), 15);

    // simultaneous write + clear from a clean state
    RESET = 1'b1; run(2); RESET = 1'b0; run(2);
    M68K_DATA_IN = 8'h11; nSNDWR = 1'b0; nSDZ80CLR = 1'b0; tick();
    nSNDWR = 1'b1; nSDZ80CLR = 1'b1; run(2);
    check("sim_pending", int'(CMD_PENDING), 1);
    check("sim_ovr", int'(OVERRUN_CNT), 0);
    nSDZ80R = 1'b0; run(2);
    check("sim_cmd", int'(SDD_OUT), 8'h11);
    nSDZ80R = 1'b1; run(30);

    // write with NMI disabled
    NMI_EN = 1'b0; low_cnt = 0;
    pulse_wr(8'h22); run(30);
    check("nmi_disabled", low_cnt, 0);

    // second write ten cycles into a pulse extends it
    NMI_EN = 1'b1; run(2); low_cnt = 0;
    pulse_wr(8'h33); run(9);
    pulse_wr(8'h34); run(45);
    check("nmi_extend", low_cnt, 10 + NMI_LEN);

    // NMI_EN dropped mid-pulse
    pulse_wr(8'h44); run(6);
    check("nmi_mid_low", int'(nNMI_REQ), 0);
    NMI_EN = 1'b0; tick(); tick();
    check("nmi_cancel", int'(nNMI_REQ), 1);
    NMI_EN = 1'b1; run(3);

    // reset mid-pulse with the write strobe held low
    pulse_wr(8'h55); run(4);
    nSDZ80CLR = 1'b0; tick(); nSDZ80CLR = 1'b1; run(2);
    pulse_wr(8'h66); run(4);
    nSNDWR = 1'b0; RESET = 1'b1; run(2);
    check("rst_mid_nmi", int'(nNMI_REQ), 1);
    check("rst_mid_pending", int'(CMD_PENDING), 0);
    RESET = 1'b0; run(5);
    check("no_cmd_held_low", int'(CMD_PENDING), 0);
    nSNDWR = 1'b1; tick(); nSNDWR = 1'b0; run(3);
    check("cmd_after_rearm", int'(CMD_PENDING), 1);
    nSNDWR = 1'b1; run(30);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) nSNDWR    = ~nSNDWR;
      if ($urandom_range(3) == 0) nSNDRD    = ~nSNDRD;
      if ($urandom_range(3) == 0) nSDZ80R   = ~nSDZ80R;
      if ($urandom_range(3) == 0) nSDZ80W   = ~nSDZ80W;
      if ($urandom_range(5) == 0) nSDZ80CLR = ~nSDZ80CLR;
      M68K_DATA_IN = 8'($urandom);
      SDD_IN       = 8'($urandom);
      NMI_EN       = ($urandom_range(31) != 0);
      RESET        = ($urandom_range(249) == 0);
      tick();
    end
    RESET = 1'b0; run(2);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
